// File: rtl/counter_pkg.sv
// ============================================================================
// Module : counter_pkg
// Brief  : Shared constants, state type and sequence helpers for the 2..6
//          counter sequence checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_pkg;

    localparam logic [2:0] SEQ_MIN = 3'd2;
    localparam logic [2:0] SEQ_MAX = 3'd6;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } chk_state_t;

    function automatic logic [2:0] seq_next(input logic [2:0] q);
        return (q == SEQ_MAX) ? SEQ_MIN : q + 3'd1;
    endfunction

    function automatic logic seq_legal(input logic [2:0] q);
        return (q >= SEQ_MIN) && (q <= SEQ_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Saturating event counter; a clear and an increment in the same
//          cycle leave the count at one.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] C_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q;
        if (inc && (cnt_d != C_MAX)) begin
            cnt_d = cnt_d + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/counter_seq_checker.sv
// ============================================================================
// Module : counter_seq_checker
// Brief  : Locks onto a 2->3->4->5->6->2 counter and flags sequence breaks.
//          Define COUNTER_CHK_STALL_EN to accept a held value as legal.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_seq_checker
    import counter_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       q_in,
    input  logic             clr,
    output logic             locked,
    output logic [2:0]       exp_q,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt
);

    localparam logic [3:0] C_LOCK_CNT = LOCK_CNT[3:0];

    chk_state_t state_q, state_d;
    logic [2:0] q_prev_q, q_prev_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic       locked_q;
    logic [2:0] exp_q_q;
    logic       err_pulse_q;
    logic       err_sticky_q;

    logic w_legal, w_match, w_stall, w_err, w_wrap;

    always_comb begin
        state_d     = state_q;
        q_prev_d    = q_prev_q;
        match_cnt_d = match_cnt_q;
        w_err       = 1'b0;
        w_wrap      = 1'b0;
        w_legal     = seq_legal(q_in);
        w_match     = (q_in == seq_next(q_prev_q));
`ifdef COUNTER_CHK_STALL_EN
        w_stall     = (q_in == q_prev_q);
`else
        w_stall     = 1'b0;
`endif
        case (state_q)
            ST_UNLOCKED: begin
                if (w_legal) begin
                    state_d     = ST_ACQUIRE;
                    q_prev_d    = q_in;
                    match_cnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (!w_legal) begin
                    state_d     = ST_UNLOCKED;
                    match_cnt_d = '0;
                end else if (!w_stall) begin
                    q_prev_d = q_in;
                    if (w_match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_d == C_LOCK_CNT) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (!w_stall) begin
                    if (w_match) begin
                        q_prev_d = q_in;
                        w_wrap   = (q_prev_q == SEQ_MAX);
                    end else begin
                        // Illegal values can never match, so they land here too.
                        state_d     = ST_UNLOCKED;
                        match_cnt_d = '0;
                        w_err       = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_UNLOCKED;
                match_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_UNLOCKED;
            q_prev_q     <= '0;
            match_cnt_q  <= '0;
            locked_q     <= 1'b0;
            exp_q_q      <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_prev_q     <= q_prev_d;
            match_cnt_q  <= match_cnt_d;
            locked_q     <= (state_d == ST_LOCKED);
            exp_q_q      <= (state_d == ST_LOCKED) ? seq_next(q_prev_d) : 3'd0;
            err_pulse_q  <= w_err;
            err_sticky_q <= (err_sticky_q & ~clr) | w_err;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (w_err),
        .cnt   (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (w_wrap),
        .cnt   (wrap_cnt)
    );

    assign locked     = locked_q;
    assign exp_q      = exp_q_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_checker.sv
// ============================================================================
// Module : tb_counter_seq_checker
// Brief  : Self-checking bench for counter_seq_checker against a behavioural
//          sequence model; honours COUNTER_CHK_STALL_EN like the design.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_seq_checker;

    localparam int LOCK_CNT = 3;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef COUNTER_CHK_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       q_in = 3'd0;
    logic             clr = 1'b0;
    logic             locked;
    logic [2:0]       exp_q;
    logic             err_pulse;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode 0=hunting, 1=acquiring, 2=tracking
    int m_mode, m_prev, m_run, m_err, m_wrap;
    int m_sticky, m_pulse;

    always #5 clk = ~clk;

    counter_seq_checker #(.LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_in       (q_in),
        .clr        (clr),
        .locked     (locked),
        .exp_q      (exp_q),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .wrap_cnt   (wrap_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic int succ(input int v);
        return (v == 6) ? 2 : v + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_run = 0; m_err = 0; m_wrap = 0;
        m_sticky = 0; m_pulse = 0;
    endtask

    task automatic model_update(input int q, input bit c);
        bit legal, hold, ev_err, ev_wrap;
        legal   = (q >= 2) && (q <= 6);
        hold    = STALL && (q == m_prev);
        ev_err  = 1'b0;
        ev_wrap = 1'b0;
        if (m_mode == 0) begin
            if (legal) begin m_mode = 1; m_prev = q; m_run = 0; end
        end else if (m_mode == 1) begin
            if (!legal) m_mode = 0;
            else if (!hold) begin
                if (q == succ(m_prev)) begin
                    m_run++;
                    if (m_run == LOCK_CNT) m_mode = 2;
                end else m_run = 0;
                m_prev = q;
            end
        end else begin
            if (!hold) begin
                if (q == succ(m_prev)) begin
                    ev_wrap = (m_prev == 6);
                    m_prev  = q;
                end else begin
                    ev_err = 1'b1;
                    m_mode = 0;
                end
            end
        end
        if (c) begin m_err = 0; m_wrap = 0; m_sticky = 0; end
        if (ev_err) begin
            m_sticky = 1;
            if (m_err < CNT_MAX) m_err++;
        end
        if (ev_wrap && m_wrap < CNT_MAX) m_wrap++;
        m_pulse = ev_err ? 1 : 0;
    endtask

    task automatic check_all();
        chk("locked",     32'(locked),     32'(m_mode == 2));
        chk("exp_q",      32'(exp_q),      32'((m_mode == 2) ? succ(m_prev) : 0));
        chk("err_pulse",  32'(err_pulse),  32'(m_pulse));
        chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
        chk("err_cnt",    32'(err_cnt),    32'(m_err));
        chk("wrap_cnt",   32'(wrap_cnt),   32'(m_wrap));
    endtask

    task automatic step(input logic [2:0] q, input logic c);
        @(negedge clk);
        q_in = q;
        clr  = c;
        @(posedge clk);
        model_update(int'(q), c);
        #1;
        check_all();
    endtask

    task automatic lock_up();
        step(3'd2, 1'b0); step(3'd3, 1'b0); step(3'd4, 1'b0); step(3'd5, 1'b0);
    endtask

    initial begin
        logic [2:0] d;
        int r;
        model_reset();
        #3;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Lock onto the sequence and wrap once
        step(3'd2, 1'b0); step(3'd3, 1'b0); step(3'd4, 1'b0);
        chk("pre_lock", 32'(locked), 32'd0);
        step(3'd5, 1'b0);
        chk("lock_after_3", 32'(locked), 32'd1);
        chk("lock_exp", 32'(exp_q), 32'd6);
        step(3'd6, 1'b0); step(3'd2, 1'b0); step(3'd3, 1'b0);
        chk("wrap_one", 32'(wrap_cnt), 32'd1);
        chk("err_zero", 32'(err_cnt), 32'd0);

        // Skip 4->6 while locked
        step(3'd4, 1'b0); step(3'd6, 1'b0);
        chk("skip_pulse", 32'(err_pulse), 32'd1);
        chk("skip_cnt", 32'(err_cnt), 32'd1);
        chk("skip_sticky", 32'(err_sticky), 32'd1);
        chk("skip_unlock", 32'(locked), 32'd0);
        step(3'd2, 1'b0);
        chk("pulse_one_cycle", 32'(err_pulse), 32'd0);
        step(3'd3, 1'b0); step(3'd4, 1'b0); step(3'd5, 1'b0);
        chk("relock", 32'(locked), 32'd1);

        // Asynchronous reset while locked
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_sum", 32'({locked, exp_q, err_pulse, err_sticky, err_cnt, wrap_cnt}), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal values only
        for (int i = 0; i < 12; i++) step((i % 2) ? 3'd0 : 3'd7, 1'b0);
        chk("illegal_unlocked", 32'(locked), 32'd0);
        chk("illegal_no_err", 32'(err_cnt), 32'd0);

        // Saturate the error counter, then clear coincident with an error
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            lock_up();
            step(3'd7, 1'b0);
        end
        chk("err_saturated", 32'(err_cnt), 32'(CNT_MAX));
        lock_up();
        step(3'd7, 1'b1);
        chk("clr_with_err", 32'(err_cnt), 32'd1);
        chk("clr_with_err_sticky", 32'(err_sticky), 32'd1);

        // Clear coincident with a wrap
        lock_up();
        step(3'd6, 1'b0);
        step(3'd2, 1'b1);
        chk("clr_with_wrap", 32'(wrap_cnt), 32'd1);
        chk("clr_with_wrap_err", 32'(err_cnt), 32'd0);

        // Repeated value while locked
        step(3'd3, 1'b1);
        step(3'd3, 1'b0);
        step(3'd4, 1'b0);
        chk("repeat_err_cnt", 32'(err_cnt), STALL ? 32'd0 : 32'd1);

        // Randomized traffic, mostly well-formed
        d = 3'd2;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 75)      d = 3'(succ(int'(d) < 2 || int'(d) > 6 ? 1 : int'(d)));
            else if (r < 85) d = d;
            else             d = 3'($urandom_range(0, 7));
            step(d, ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
